// File: rtl/act_skew_feeder.sv
// Column-edge activation feeder: FIFO-buffered vectors emitted diagonally skewed per row.
// Optional ACT_SKEW_STALL_CNT_EN adds a 16-bit bubble counter output (stall_cnt).
module act_skew_feeder #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_data,
  input  logic                 start,
  input  logic [7:0]           k_len,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*DW-1:0]   out_a,
  output logic [ROWS-1:0]      out_f
`ifdef ACT_SKEW_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned VW = ROWS * DW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [7:0] FLUSH_INIT = 8'(ROWS - 1);

  logic [VW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q;

  logic [1:0]    state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    fl_q, fl_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          push, pop;
  logic [VW-1:0] pop_data;

  assign push     = in_valid && in_ready_q;
  assign pop_data = mem_q[rptr_q];
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, pop decision and FIFO occupancy
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fl_d    = fl_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          if (k_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = k_len;
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (cnt_q != '0) begin
          pop   = 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_FLUSH;
            fl_d    = FLUSH_INIT;
          end
        end
      end
      S_FLUSH: begin
        if (fl_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          fl_d = fl_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Stay busy through the done cycle of a real tile only.
    busy_d = (state_d != S_IDLE) || (state_q == S_FLUSH);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      fl_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      fl_q       <= fl_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != CW'(DEPTH));
      if (push) begin
        mem_q[wptr_q] <= in_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
    end
  end

  // Row r: r skew stages plus an output stage; data advances only with its valid, so the output holds on bubbles
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    logic          v_q [r+1];
    logic [DW-1:0] d_q [r+1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i <= r; i++) begin
          v_q[i] <= 1'b0;
          d_q[i] <= '0;
        end
      end else begin
        v_q[0] <= pop;
        if (pop) d_q[0] <= pop_data[r*DW +: DW];
        for (int i = 1; i <= r; i++) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign out_f[r]           = v_q[r];
    assign out_a[r*DW +: DW]  = d_q[r];
  end

`ifdef ACT_SKEW_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        bubble, start_acc;

  assign bubble    = (state_q == S_FEED) && (cnt_q == '0);
  assign start_acc = (state_q == S_IDLE) && start && !done_q && (k_len != 8'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (bubble && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomized + directed bench for act_skew_feeder against a cycle-scheduled reference model.
module tb_act_skew_feeder;
  localparam int ROWS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 32;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic                 start;
  logic [7:0]           k_len;
  logic                 busy;
  logic                 done;
  logic [ROWS*DW-1:0]   out_a;
  logic [ROWS-1:0]      out_f;
`ifdef ACT_SKEW_STALL_CNT_EN
  logic [15:0]          stall_cnt;
`endif

  always #5 clk = ~clk;

  act_skew_feeder #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .done     (done),
    .out_a    (out_a),
    .out_f    (out_f)
`ifdef ACT_SKEW_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue FIFO, tile bookkeeping, and per-cycle fire schedule
  logic [ROWS*DW-1:0] m_q[$];
  bit                 m_feed;
  int                 m_rem;
  int                 m_done_cyc;
  int                 m_busy_from, m_busy_to;
  int                 m_stall;
  int                 cyc = 0;
  bit                 m_pushed;
  bit                 s_v [SW][ROWS];
  logic [DW-1:0]      s_d [SW][ROWS];
  logic [DW-1:0]      m_a [ROWS];
  bit                 m_f [ROWS];

  task automatic m_reset();
    m_q.delete();
    m_feed = 0; m_rem = 0; m_done_cyc = -10;
    m_busy_from = 1; m_busy_to = 0; m_stall = 0; m_pushed = 0;
    for (int i = 0; i < SW; i++)
      for (int r = 0; r < ROWS; r++) begin s_v[i][r] = 0; s_d[i][r] = '0; end
    for (int r = 0; r < ROWS; r++) begin m_a[r] = '0; m_f[r] = 0; end
  endtask

  // Advance model by the clock edge that ends cycle cyc
  task automatic m_edge();
    int c = cyc;
    int sz0 = m_q.size();
    int n;
    logic [ROWS*DW-1:0] v;
    bit acc;
    acc = start && !m_feed && (m_done_cyc < c);
    m_pushed = 0;
    if (m_feed) begin
      if (sz0 > 0) begin
        v = m_q.pop_front();
        for (int r = 0; r < ROWS; r++) begin
          s_v[(c + 1 + r) % SW][r] = 1;
          s_d[(c + 1 + r) % SW][r] = v[r*DW +: DW];
        end
        m_rem--;
        if (m_rem == 0) begin
          m_feed = 0;
          m_done_cyc = c + 1 + ROWS;
          m_busy_to = m_done_cyc;
        end
      end else if (m_stall < 65535) begin
        m_stall++;
      end
    end
    if (in_valid && sz0 < DEPTH) begin
      m_q.push_back(in_data);
      m_pushed = 1;
    end
    if (acc) begin
      if (k_len == 8'd0) m_done_cyc = c + 1;
      else begin
        m_feed = 1; m_rem = int'(k_len);
        m_busy_from = c + 1; m_busy_to = 1 << 30; m_stall = 0;
      end
    end
    n = c + 1;
    for (int r = 0; r < ROWS; r++) begin
      m_f[r] = s_v[n % SW][r];
      if (m_f[r]) m_a[r] = s_d[n % SW][r];
      s_v[n % SW][r] = 0;
    end
    cyc = n;
  endtask

  task automatic check_outputs();
    logic [ROWS-1:0]    ef;
    logic [ROWS*DW-1:0] ea;
    for (int r = 0; r < ROWS; r++) begin
      ef[r] = m_f[r];
      ea[r*DW +: DW] = m_a[r];
    end
    chk("out_f", 64'(out_f), 64'(ef));
    chk("out_a", 64'(out_a), 64'(ea));
    chk("busy", 64'(busy), 64'(cyc >= m_busy_from && cyc <= m_busy_to));
    chk("done", 64'(done), 64'(cyc == m_done_cyc));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
`ifdef ACT_SKEW_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) m_edge();
    else cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [ROWS*DW-1:0] vec(input int base);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(base + r + 1);
    return v;
  endfunction

  task automatic push_vecs(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_data  = vec(base + 16 * i);
      do begin tick(); guard++; end while (!m_pushed && guard < 20);
      if (!m_pushed) chk("push_timeout", 64'(0), 64'(1));
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] k);
    start = 1'b1; k_len = k;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int s, done_seen, acc_cnt, pushed;
    rstn = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; k_len = '0;
    m_reset();
    #2 rstn = 1'b0;
    #1;
    check_outputs();
    repeat (2) tick();
    rstn = 1'b1;

    // Basic skew
    push_vecs(3, 8'h00);
    pulse_start(8'd3);
    s = cyc - 1; done_seen = -1;
    repeat (10) begin
      tick();
      if (done && done_seen < 0) done_seen = cyc;
      if (cyc == s + 7) chk("basic_row3_last", 64'(out_a[3*DW +: DW]), 64'h24);
      if (cyc == s + 2) chk("basic_row0_first", 64'(out_a[DW-1:0]), 64'h01);
    end
    chk("basic_done_cycle", 64'(done_seen - s), 64'd8);

    // Bubble: start on an empty FIFO, data arrives two cycles later
    pulse_start(8'd2);
    tick();
    push_vecs(2, 8'h30);
    repeat (10) tick();
`ifdef ACT_SKEW_STALL_CNT_EN
    chk("bubble_stall", 64'(stall_cnt), 64'd2);
`endif

    // Backpressure: fill with no tile, then stream 16 vectors through
    acc_cnt = 0; pushed = 0;
    in_valid = 1'b1;
    repeat (8) begin
      in_data = vec(8'h40 + pushed);
      if (in_ready) acc_cnt++;
      tick();
      if (m_pushed) pushed++;
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd4);
    start = 1'b1; k_len = 8'd16;
    in_data = vec(8'h40 + pushed);
    tick();
    if (m_pushed) pushed++;
    start = 1'b0;
    for (int g = 0; g < 40 && pushed < 16; g++) begin
      in_data = vec(8'h40 + pushed);
      tick();
      if (m_pushed) pushed++;
    end
    in_valid = 1'b0;
    chk("bp_pushed", 64'(pushed), 64'd16);
    repeat (12) tick();

    // k_len == 0
    pulse_start(8'd0);
    chk("k0_done", 64'(done), 64'd1);
    chk("k0_busy", 64'(busy), 64'd0);
    repeat (3) tick();

    // Reset mid-FEED
    push_vecs(4, 8'h60);
    pulse_start(8'd5);
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    m_reset();
    chk("rst_out_f", 64'(out_f), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) tick();
    rstn = 1'b1;
    push_vecs(1, 8'h70);
    pulse_start(8'd1);
    repeat (8) tick();

    // start while busy (during FLUSH) is ignored
    push_vecs(2, 8'h80);
    pulse_start(8'd2);
    repeat (4) tick();
    pulse_start(8'd9);
    repeat (10) tick();
    chk("sb_busy_end", 64'(busy), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = ROWS*DW'($urandom);
      start    = ($urandom_range(0, 7) == 0);
      k_len    = 8'($urandom_range(0, 6));
      tick();
    end
    in_valid = 1'b0; start = 1'b0;
    repeat (60) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
